// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a big-endian byte image into instruction memory, then releases CPU reset
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   word_count,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR} state_t;
    state_t            state, state_n;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       shift_q;
    logic              last_flag;
    logic              accept;
    assign accept = in_valid && state == LOAD;
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    // next state and state-decoded outputs; later assignments take priority
    always_comb begin
        in_ready = state == LOAD;
        wr_en = state == WRITE;
        done = state == DONE;
        err = state == ERROR;
        cpu_rst = state != DONE;
        state_n = state;
        if (state == IDLE) state_n = LOAD;
        if (accept) state_n = byte_cnt == 2'd3 ? WRITE : in_last ? ERROR : LOAD;
        if (state == WRITE) state_n = last_flag ? DONE : &word_addr ? ERROR : LOAD;
    end
    // byte assembly, write-port capture on the 4th byte, and address/count advance after each write
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            byte_cnt <= '0;
            word_addr <= '0;
            word_count <= '0;
            shift_q <= '0;
            last_flag <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (accept) begin
                shift_q <= {shift_q[23:0], in_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    last_flag <= in_last;
                    wr_addr <= word_addr;
                    wr_data <= {shift_q[23:0], in_data};
                end
            end
            if (state == WRITE) begin
                word_addr <= word_addr + 1'b1;
                word_count <= word_count + 1'b1;
            end
        end
endmodule
